// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encodings and owner codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational two-way picker: bit 0 = CPU, bit 1 = loader.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_mode,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = OWNER_CPU;
    // On a tie, mode 1 favours the loader; otherwise whoever did not go last.
    if (i_req == 2'b11)
      o_winner = i_mode ? OWNER_LDR : ~i_last;
    else if (i_req[1])
      o_winner = OWNER_LDR;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU and the program loader; one
// registered access at a time with gnt/done handshakes per requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_c_gnt, r_l_gnt, r_c_done, r_l_done, r_m_write;
  logic [DATA_W-1:0]   r_c_rdata, r_l_rdata;

  logic                w_winner;
  logic                w_valid;

  arb_rr2 u_pick (
    .i_req    ({l_req, c_req}),
    .i_last   (r_owner),
    .i_mode   (PRIO_MODE != 0),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_owner   <= OWNER_LDR;
      r_cnt     <= '0;
      r_c_gnt   <= 1'b0;
      r_l_gnt   <= 1'b0;
      r_c_done  <= 1'b0;
      r_l_done  <= 1'b0;
      r_m_write <= 1'b0;
      r_c_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      r_c_gnt   <= 1'b0;
      r_l_gnt   <= 1'b0;
      r_c_done  <= 1'b0;
      r_l_done  <= 1'b0;
      r_m_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_we    <= (w_winner == OWNER_LDR) ? l_we    : c_we;
            r_addr  <= (w_winner == OWNER_LDR) ? l_addr  : c_addr;
            r_wdata <= (w_winner == OWNER_LDR) ? l_wdata : c_wdata;
            r_owner <= w_winner;
            r_c_gnt <= (w_winner == OWNER_CPU);
            r_l_gnt <= (w_winner == OWNER_LDR);
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            r_m_write <= 1'b1;
            r_c_done  <= (r_owner == OWNER_CPU);
            r_l_done  <= (r_owner == OWNER_LDR);
            r_state   <= ST_IDLE;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT - 1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner == OWNER_LDR) r_l_rdata <= m_rdata;
            else                      r_c_rdata <= m_rdata;
            r_c_done <= (r_owner == OWNER_CPU);
            r_l_done <= (r_owner == OWNER_LDR);
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Address and data come straight from the captured fields, so the RAM
  // sees a stable address from the grant until the next accepted request.
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign m_write = r_m_write;
  assign c_gnt   = r_c_gnt;
  assign l_gnt   = r_l_gnt;
  assign c_done  = r_c_done;
  assign l_done  = r_l_done;
  assign c_rdata = r_c_rdata;
  assign l_rdata = r_l_rdata;
  assign busy    = (r_state != ST_IDLE);
  assign owner   = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin instance with a RAM model,
// plus a loader-priority instance for tie behaviour.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 1;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n    = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [7:0]  c_addr = '0, l_addr = '0;
  logic [15:0] c_wdata = '0, l_wdata = '0;
  logic        c_gnt, c_done, l_gnt, l_done, m_write, busy, owner;
  logic [15:0] c_rdata, l_rdata, m_wdata, m_rdata;
  logic [7:0]  m_addr;

  logic        p1_c_req = 1'b0, p1_l_req = 1'b0;
  logic        p1_c_gnt, p1_c_done, p1_l_gnt, p1_l_done, p1_m_write, p1_busy, p1_owner;
  logic [15:0] p1_c_rdata, p1_l_rdata, p1_m_wdata;
  logic [15:0] p1_m_rdata = '0;
  logic [7:0]  p1_m_addr;
  int          p1_done_cnt = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(RD_LAT), .PRIO_MODE(0)) u_dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(RD_LAT), .PRIO_MODE(1)) u_dut_prio (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n),
    .c_req(p1_c_req), .c_we(1'b1), .c_addr(8'h01), .c_wdata(16'h1111),
    .c_gnt(p1_c_gnt), .c_done(p1_c_done), .c_rdata(p1_c_rdata),
    .l_req(p1_l_req), .l_we(1'b1), .l_addr(8'h02), .l_wdata(16'h2222),
    .l_gnt(p1_l_gnt), .l_done(p1_l_done), .l_rdata(p1_l_rdata),
    .m_addr(p1_m_addr), .m_wdata(p1_m_wdata), .m_write(p1_m_write), .m_rdata(p1_m_rdata),
    .busy(p1_busy), .owner(p1_owner)
  );

  // RAM with one cycle of registered read latency.
  logic [15:0] ram [256];
  always @(posedge CLOCK_50) begin
    if (m_write) ram[m_addr] <= m_wdata;
    m_rdata <= ram[m_addr];
  end

  always @(posedge CLOCK_50) begin
    if (p1_c_done || p1_l_done) p1_done_cnt <= p1_done_cnt + 1;
  end

  typedef struct {
    logic        who;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_mem [256];
  logic [15:0] exp_c_rd = '0, exp_l_rd = '0;
  int          n_assert = 0, n_fail = 0;
  int          cyc = 0, gnt_cyc = 0;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic who, input logic we, input logic [7:0] addr, input logic [15:0] data);
    if (who) begin l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = data; end
    else     begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = data; end
  endtask

  task automatic grant(input logic who, input string tag);
    exp_t e;
    int   n = 0;
    while (n < 20 && !(c_gnt || l_gnt)) begin tick(); n++; end
    check({tag, "_gnt_seen"}, 32'(c_gnt | l_gnt), 1);
    check({tag, "_c_gnt"}, 32'(c_gnt), 32'(who == 1'b0));
    check({tag, "_l_gnt"}, 32'(l_gnt), 32'(who == 1'b1));
    e.who  = who;
    e.we   = who ? l_we : c_we;
    e.addr = who ? l_addr : c_addr;
    e.lat  = e.we ? 1 : 1 + RD_LAT;
    if (e.we) begin
      e.data = who ? l_wdata : c_wdata;
      exp_mem[e.addr] = e.data;
    end else begin
      e.data = exp_mem[e.addr];
    end
    sb.push_back(e);
    if (who) l_req = 1'b0; else c_req = 1'b0;
    gnt_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (n < 20 && !(c_done || l_done)) begin tick(); n++; end
    check({tag, "_done_seen"}, 32'(c_done | l_done), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_c_done"}, 32'(c_done), 32'(e.who == 1'b0));
      check({tag, "_l_done"}, 32'(l_done), 32'(e.who == 1'b1));
      check({tag, "_owner"}, 32'(owner), 32'(e.who));
      check({tag, "_latency"}, 32'(cyc - gnt_cyc), 32'(e.lat));
      check({tag, "_no_gnt"}, 32'({c_gnt, l_gnt}), 0);
      if (e.we) begin
        check({tag, "_m_write"}, 32'(m_write), 1);
        check({tag, "_m_addr"}, 32'(m_addr), 32'(e.addr));
        check({tag, "_m_wdata"}, 32'(m_wdata), 32'(e.data));
      end else begin
        check({tag, "_m_write_rd"}, 32'(m_write), 0);
        if (e.who) exp_l_rd = e.data; else exp_c_rd = e.data;
      end
      check({tag, "_c_rdata"}, 32'(c_rdata), 32'(exp_c_rd));
      check({tag, "_l_rdata"}, 32'(l_rdata), 32'(exp_l_rd));
      $display("txn %s who=%0d we=%0d addr=%02h data=%04h lat=%0d", tag, e.who, e.we, e.addr, e.data, cyc - gnt_cyc);
    end
    tick();
    check({tag, "_pulse_end"}, 32'({c_done, l_done, m_write}), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    c_req = 1'b0; l_req = 1'b0; p1_c_req = 1'b0; p1_l_req = 1'b0;
    repeat (3) tick();
    check({tag, "_pulses"}, 32'({c_gnt, l_gnt, c_done, l_done, m_write, busy}), 0);
    check({tag, "_owner"}, 32'(owner), 1);
    check({tag, "_m_bus"}, {m_addr, m_wdata}, 0);
    check({tag, "_rdata"}, {c_rdata, l_rdata}, 0);
    rst_n = 1'b1;
    exp_c_rd = '0;
    exp_l_rd = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; exp_mem[i] = '0; end

    // Reset and quiet idle
    do_reset("rst");
    for (int i = 0; i < 2; i++) begin
      tick();
      check("idle_quiet", 32'({c_gnt, l_gnt, busy, m_write}), 0);
    end

    // CPU write, then read back
    issue(1'b0, 1'b1, 8'h2A, 16'h1234);
    grant(1'b0, "cpu_wr");
    wait_done("cpu_wr");
    issue(1'b0, 1'b0, 8'h2A, 16'h0000);
    grant(1'b0, "cpu_rd");
    wait_done("cpu_rd");

    // Round-robin ties from reset: C, L, C, L
    do_reset("rst2");
    for (int r = 0; r < 2; r++) begin
      issue(1'b0, 1'b1, 8'(8'h10 + r), 16'(16'hC000 + r));
      issue(1'b1, 1'b1, 8'(8'h20 + r), 16'(16'hA000 + r));
      grant(1'b0, "tie_c");
      wait_done("tie_c");
      grant(1'b1, "tie_l");
      wait_done("tie_l");
    end

    // Loader request arriving while the CPU read is in progress
    issue(1'b0, 1'b0, 8'h10, 16'h0000);
    grant(1'b0, "ovl_cpu_rd");
    tick();
    check("ovl_busy", 32'(busy), 1);
    issue(1'b1, 1'b1, 8'h40, 16'hBEEF);
    wait_done("ovl_cpu_rd");
    grant(1'b1, "ovl_ldr_wr");
    wait_done("ovl_ldr_wr");
    issue(1'b1, 1'b0, 8'h40, 16'h0000);
    grant(1'b1, "ldr_rd");
    wait_done("ldr_rd");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_quiet", 32'({c_gnt, l_gnt, busy}), 0);
    end
    check("sb_empty", 32'(sb.size()), 0);

    // Loader-priority instance: loader wins both ties, even right after owning
    p1_c_req = 1'b1; p1_l_req = 1'b1;
    tick();
    check("p1_tie1_l_gnt", 32'({p1_l_gnt, p1_c_gnt}), 32'h2);
    p1_l_req = 1'b0;
    tick();
    p1_l_req = 1'b1;
    tick();
    check("p1_tie2_l_gnt", 32'({p1_l_gnt, p1_c_gnt}), 32'h2);
    p1_l_req = 1'b0;
    begin
      int n = 0;
      while (n < 20 && !p1_c_gnt) begin tick(); n++; end
    end
    check("p1_cpu_gnt", 32'({p1_l_gnt, p1_c_gnt}), 32'h1);
    p1_c_req = 1'b0;
    repeat (4) tick();
    check("p1_done_cnt", 32'(p1_done_cnt), 3);
    check("p1_idle", 32'({p1_busy, p1_owner}), 0);

    // Async reset during ACCESS of a CPU write aborts it
    issue(1'b0, 1'b1, 8'h55, 16'h7777);
    grant(1'b0, "abort");
    sb.delete();
    #2 rst_n = 1'b0;
    #1;
    check("abort_async", 32'({c_gnt, busy, m_write, owner}), 32'h1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", 32'({c_done, l_done, m_write}), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
